// File: rtl/multichannel_echo_delay.sv
// rtl/multichannel_echo_delay.sv - multichannel delay/echo effect over a shared ring-buffer RAM
//
// Ports:
//   clk_in, rst_n_in     audio clock, asynchronous active-low reset
//   sample_valid_in      one-cycle frame strobe, qualifies data_in and all settings
//   data_in / data_out   CHANNELS packed signed samples, channel c at [c*WIDTH +: WIDTH]
//   mode_in              00/11 bypass, 01 single-repeat delay, 10 feedback echo
//   delay_len_in         delay in frames (0 behaves as 1)
//   feedback_in, mix_in  unsigned gains, value / 2^GAIN_W; dry weight is 2^GAIN_W - mix_in
//   valid_out            one-cycle pulse when data_out is updated
//   ready_out            idle, the next strobe will be accepted
//   overrun_out          sticky, a strobe was dropped while a frame was in flight
module multichannel_echo_delay #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int MAX_DELAY = 32768,
  parameter int GAIN_W    = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         sample_valid_in,
  input  logic [CHANNELS*WIDTH-1:0]    data_in,
  input  logic [1:0]                   mode_in,
  input  logic [$clog2(MAX_DELAY)-1:0] delay_len_in,
  input  logic [GAIN_W-1:0]            feedback_in,
  input  logic [GAIN_W-1:0]            mix_in,
  output logic [CHANNELS*WIDTH-1:0]    data_out,
  output logic                         valid_out,
  output logic                         ready_out,
  output logic                         overrun_out
);

  localparam int PW    = $clog2(MAX_DELAY);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = CW + PW;
  localparam int DEPTH = CHANNELS * MAX_DELAY;
  localparam int P     = WIDTH + GAIN_W + 2;

  localparam logic signed [P-1:0] GAIN_ONE = P'(1) << GAIN_W;
  localparam logic signed [P-1:0] SAT_MAX  = (P'(1) <<< (WIDTH - 1)) - P'(1);
  localparam logic signed [P-1:0] SAT_MIN  = -(P'(1) <<< (WIDTH - 1));

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RD, S_W1, S_W2, S_MAC, S_WR, S_OUT
  } state_t;

  state_t                    state;
  logic [AW-1:0]             clr_addr;
  logic [CW-1:0]             ch;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             dly_q;
  logic [CHANNELS*WIDTH-1:0] x_lat;
  logic [CHANNELS*WIDTH-1:0] out_buf;
  logic [1:0]                mode_q;
  logic [GAIN_W-1:0]         fb_q;
  logic [GAIN_W-1:0]         mix_q;
  logic signed [P-1:0]       fb_prod;
  logic signed [P-1:0]       mix_sum;

  // Ring buffer: channel index in the upper address bits, frame pointer below.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q1, rd_q2;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_wdata;

  assign mem_raddr = {ch, wr_ptr - dly_q};

  // Read is only launched in RD so it can never collide with a CLEAR/WR write.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state == S_RD) rd_q1 <= mem[mem_raddr];
    rd_q2 <= rd_q1;
  end

  logic signed [WIDTH-1:0] x_cur, d_cur;
  logic signed [P-1:0]     x_ext, d_ext, fb_ext, mix_ext, dry_ext, echo_sum;
  logic [WIDTH-1:0]        echo_word, out_word;
  logic                    is_echo, is_bypass;

  assign is_echo   = (mode_q == 2'b10);
  assign is_bypass = (mode_q[1] == mode_q[0]);

  always_comb begin
    x_cur    = x_lat[int'(ch)*WIDTH +: WIDTH];
    d_cur    = rd_q2;
    x_ext    = P'(x_cur);
    d_ext    = P'(d_cur);
    fb_ext   = P'(fb_q);
    mix_ext  = P'(mix_q);
    dry_ext  = GAIN_ONE - mix_ext;
    echo_sum = x_ext + (fb_prod >>> GAIN_W);
    if (echo_sum > SAT_MAX)      echo_word = WIDTH'(SAT_MAX);
    else if (echo_sum < SAT_MIN) echo_word = WIDTH'(SAT_MIN);
    else                         echo_word = WIDTH'(echo_sum);
    // The weighted sum cannot exceed the larger input magnitude, so no clamp here.
    out_word  = is_bypass ? x_cur : WIDTH'(mix_sum >>> GAIN_W);
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = '0;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (state == S_WR) begin
      mem_we    = 1'b1;
      mem_waddr = {ch, wr_ptr};
      mem_wdata = is_echo ? echo_word : x_cur;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= S_CLEAR;
      clr_addr    <= '0;
      ch          <= '0;
      wr_ptr      <= '0;
      dly_q       <= PW'(1);
      x_lat       <= '0;
      mode_q      <= '0;
      fb_q        <= '0;
      mix_q       <= '0;
      fb_prod     <= '0;
      mix_sum     <= '0;
      out_buf     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      ready_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (sample_valid_in && state != S_CLEAR && state != S_IDLE) overrun_out <= 1'b1;
      case (state)
        S_CLEAR: begin
          if (clr_addr == AW'(DEPTH - 1)) begin
            state     <= S_IDLE;
            ready_out <= 1'b1;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        S_IDLE: begin
          if (sample_valid_in) begin
            x_lat     <= data_in;
            mode_q    <= mode_in;
            fb_q      <= feedback_in;
            mix_q     <= mix_in;
            dly_q     <= (delay_len_in == '0) ? PW'(1) : delay_len_in;
            ch        <= '0;
            ready_out <= 1'b0;
            state     <= S_RD;
          end
        end
        S_RD:  state <= S_W1;
        S_W1:  state <= S_W2;
        S_W2:  state <= S_MAC;
        S_MAC: begin
          fb_prod <= d_ext * fb_ext;
          mix_sum <= x_ext * dry_ext + d_ext * mix_ext;
          state   <= S_WR;
        end
        S_WR: begin
          out_buf[int'(ch)*WIDTH +: WIDTH] <= out_word;
          if (ch == CW'(CHANNELS - 1)) begin
            state <= S_OUT;
          end else begin
            ch    <= ch + CW'(1);
            state <= S_RD;
          end
        end
        S_OUT: begin
          data_out  <= out_buf;
          valid_out <= 1'b1;
          ready_out <= 1'b1;
          wr_ptr    <= wr_ptr + PW'(1);
          state     <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_multichannel_echo_delay.sv
// tb/tb_multichannel_echo_delay.sv - directed self-checking bench for multichannel_echo_delay
module tb_multichannel_echo_delay;

  localparam int WIDTH     = 16;
  localparam int CHANNELS  = 2;
  localparam int MAX_DELAY = 16;
  localparam int GAIN_W    = 8;
  localparam int DW        = WIDTH * CHANNELS;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          sample_valid_in;
  logic [DW-1:0] data_in;
  logic [1:0]    mode_in;
  logic [3:0]    delay_len_in;
  logic [7:0]    feedback_in;
  logic [7:0]    mix_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic          overrun_out;

  int vectors     = 0;
  int miscompares = 0;

  multichannel_echo_delay #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .GAIN_W(GAIN_W)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_valid_in(sample_valid_in),
    .data_in(data_in), .mode_in(mode_in), .delay_len_in(delay_len_in),
    .feedback_in(feedback_in), .mix_in(mix_in), .data_out(data_out),
    .valid_out(valid_out), .ready_out(ready_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    int n;
    logic valid_seen;
    @(negedge clk_in);
    rst_n_in        = 1'b0;
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_ready", 32'(ready_out), 32'h0);
    check("rst_overrun", 32'(overrun_out), 32'h0);
    rst_n_in   = 1'b1;
    n          = 0;
    valid_seen = 1'b0;
    while (!ready_out && n < 100) begin
      sample_valid_in = (n == 5);
      @(negedge clk_in);
      n++;
      if (valid_out) valid_seen = 1'b1;
    end
    sample_valid_in = 1'b0;
    check("clear_cycles", n, 32);
    check("clear_no_valid", 32'(valid_seen), 32'h0);
    check("clear_strobe_no_overrun", 32'(overrun_out), 32'h0);
  endtask

  task automatic run_frame(input logic [DW-1:0] din, input logic [1:0] mode,
                           input logic [3:0] dly, input logic [7:0] fb, input logic [7:0] mix,
                           output logic [DW-1:0] got, output int lat);
    @(negedge clk_in);
    data_in         = din;
    mode_in         = mode;
    delay_len_in    = dly;
    feedback_in     = fb;
    mix_in          = mix;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    data_in         = ~din;
    mode_in         = ~mode;
    delay_len_in    = ~dly;
    feedback_in     = ~fb;
    mix_in          = ~mix;
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(negedge clk_in);
      lat++;
    end
    got = data_out;
    @(negedge clk_in);
    check("valid_one_cycle", 32'(valid_out), 32'h0);
  endtask

  logic [DW-1:0] got;
  int            lat;
  logic [15:0]   exp0, exp1;
  logic [15:0]   sat0 [4];
  logic [15:0]   sat1 [4];
  int            extra;

  initial begin
    rst_n_in        = 1'b0;
    sample_valid_in = 1'b0;
    data_in         = '0;
    mode_in         = 2'b00;
    delay_len_in    = '0;
    feedback_in     = '0;
    mix_in          = '0;
    apply_reset();

    // Delay mode: impulse comes back once, four frames later.
    for (int f = 0; f < 6; f++) begin
      run_frame((f == 0) ? {16'h0000, 16'h4000} : 32'h0, 2'b01, 4'd4, 8'd0, 8'd128, got, lat);
      exp0 = (f == 0 || f == 4) ? 16'h2000 : 16'h0000;
      check($sformatf("delay_f%0d_latency", f), lat, 11);
      check($sformatf("delay_f%0d_ch0", f), 32'(got[15:0]), 32'(exp0));
      check($sformatf("delay_f%0d_ch1", f), 32'(got[31:16]), 32'h0);
    end

    // Bypass passes channels straight through for both bypass encodings.
    run_frame({16'hBEEF, 16'h1234}, 2'b11, 4'd4, 8'd0, 8'd200, got, lat);
    check("bypass11_data", got, 32'hBEEF1234);
    run_frame({16'h8001, 16'h7FFE}, 2'b00, 4'd2, 8'd50, 8'd200, got, lat);
    check("bypass00_data", got, 32'h80017FFE);
    check("bypass00_latency", lat, 11);

    // Echo: repeats halve every four frames.
    apply_reset();
    for (int f = 0; f < 13; f++) begin
      run_frame((f == 0) ? {16'h0000, 16'h4000} : 32'h0, 2'b10, 4'd4, 8'd128, 8'd128, got, lat);
      case (f)
        0, 4:    exp0 = 16'h2000;
        8:       exp0 = 16'h1000;
        12:      exp0 = 16'h0800;
        default: exp0 = 16'h0000;
      endcase
      check($sformatf("echo_f%0d_ch0", f), 32'(got[15:0]), 32'(exp0));
      check($sformatf("echo_f%0d_ch1", f), 32'(got[31:16]), 32'h0);
    end

    // Saturation with delay 0 acting as 1, positive and negative rails.
    apply_reset();
    sat0[0] = 16'h0070; sat0[1] = 16'h7000; sat0[2] = 16'h7FEF; sat0[3] = 16'h7FEF;
    sat1[0] = 16'hFF90; sat1[1] = 16'h9000; sat1[2] = 16'h8010; sat1[3] = 16'h8010;
    for (int f = 0; f < 4; f++) begin
      run_frame({16'h9000, 16'h7000}, 2'b10, 4'd0, 8'd255, 8'd255, got, lat);
      exp0 = sat0[f];
      exp1 = sat1[f];
      check($sformatf("sat_f%0d_ch0", f), 32'(got[15:0]), 32'(exp0));
      check($sformatf("sat_f%0d_ch1", f), 32'(got[31:16]), 32'(exp1));
    end

    // Overrun: second strobe three cycles after the first is dropped.
    apply_reset();
    @(negedge clk_in);
    data_in         = {16'h5555, 16'hABCD};
    mode_in         = 2'b00;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    lat = 0;
    @(negedge clk_in); lat++;
    @(negedge clk_in); lat++;
    data_in         = {16'h1111, 16'h2222};
    sample_valid_in = 1'b1;
    @(negedge clk_in); lat++;
    sample_valid_in = 1'b0;
    while (!valid_out && lat < 40) begin
      @(negedge clk_in);
      lat++;
    end
    check("ovr_latency", lat, 11);
    check("ovr_data", data_out, 32'h5555ABCD);
    check("ovr_flag", 32'(overrun_out), 32'h1);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (valid_out) extra++;
    end
    check("ovr_no_second_valid", extra, 0);
    check("ovr_ready_after", 32'(ready_out), 32'h1);
    check("ovr_data_holds", data_out, 32'h5555ABCD);

    // Reset during MAC of channel 1 discards the frame.
    apply_reset();
    run_frame({16'h2222, 16'h1111}, 2'b00, 4'd1, 8'd0, 8'd0, got, lat);
    check("pre_abort_data", data_out, 32'h22221111);
    @(negedge clk_in);
    data_in         = {16'h2000, 16'h4000};
    mode_in         = 2'b10;
    delay_len_in    = 4'd1;
    feedback_in     = 8'd128;
    mix_in          = 8'd128;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    repeat (8) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("abort_data_zero", data_out, 32'h0);
    check("abort_valid_zero", 32'(valid_out), 32'h0);
    check("abort_ready_zero", 32'(ready_out), 32'h0);
    apply_reset();
    run_frame({16'h2000, 16'h4000}, 2'b10, 4'd1, 8'd128, 8'd128, got, lat);
    check("post_abort_f0", got, 32'h10002000);
    run_frame(32'h0, 2'b10, 4'd1, 8'd128, 8'd128, got, lat);
    check("post_abort_f1", got, 32'h10002000);
    run_frame(32'h0, 2'b10, 4'd1, 8'd128, 8'd128, got, lat);
    check("post_abort_f2", got, 32'h08001000);
    check("post_abort_latency", lat, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
